// File: rtl/fir_mac_scheduler.sv
// Round-robin sequencer that time-shares one symmetric-FIR pre-add/MAC datapath
// between NCH channels: delay-line shift, tap-pair issue, and accumulator strobes.
//
// state | meaning
// IDLE  | no sample being processed, waiting for a pending channel
// SHIFT | one cycle: shift the granted channel's delay line, ack its request
// ISSUE | HALF cycles: issue tap pair k = 0..HALF-1 for the current channel
`timescale 1ns/1ps
module fir_mac_scheduler #(
  parameter int NTAP    = 16,
  parameter int NCH     = 2,
  parameter int MAC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            ch_req,
  output logic [NCH-1:0]            ch_ack,
  output logic                      shift_en,
  output logic [2:0]                shift_ch,
  output logic                      issue_valid,
  output logic [2:0]                issue_ch,
  output logic [$clog2(NTAP)-1:0]   pair_lo,
  output logic [$clog2(NTAP)-1:0]   pair_hi,
  output logic [$clog2(NTAP/2)-1:0] coe_idx,
  output logic                      acc_clr,
  output logic                      acc_en,
  output logic                      out_valid,
  output logic [2:0]                out_ch,
  output logic                      busy,
  output logic [NCH-1:0]            ovr_err
);

  localparam int HALF = NTAP / 2;
  localparam int LW   = $clog2(NTAP);
  localparam int CW   = $clog2(HALF);
  localparam logic [LW-1:0] K_LAST = LW'(HALF - 1);
  localparam logic [LW-1:0] K_TOP  = LW'(NTAP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ISSUE = 2'd2} state_t;

  state_t           state, state_n;
  logic [NCH-1:0]   pend, pend_d, ovr_d, gnt_vec;
  logic [2:0]       rr_ptr, cur_ch, cur_n, grant_ch;
  logic             grant_vld, do_grant, k_last;
  logic [LW-1:0]    k_n;
  int               rr_dist, rr_best;

  logic             shift_en_d, issue_valid_d;
  logic [2:0]       shift_ch_d, issue_ch_d;
  logic [NCH-1:0]   ch_ack_d;
  logic [LW-1:0]    pair_lo_d, pair_hi_d;
  logic [CW-1:0]    coe_idx_d;

  logic [MAC_LAT:0]   tag_v, tag_l;
  logic [MAC_LAT-1:0] tag_f;
  logic [2:0]         tag_c [MAC_LAT+1];

  // Round-robin: smallest upward distance from the pointer (with wrap) wins.
  always_comb begin
    rr_best  = NCH;
    rr_dist  = 0;
    grant_ch = 3'd0;
    for (int c = 0; c < NCH; c++) begin
      rr_dist = (c >= int'(rr_ptr)) ? c - int'(rr_ptr) : c + NCH - int'(rr_ptr);
      if (pend[c] && rr_dist < rr_best) begin
        rr_best  = rr_dist;
        grant_ch = 3'(c);
      end
    end
    grant_vld = |pend;
  end

  assign k_last   = (state == ISSUE) && (pair_lo == K_LAST);
  assign do_grant = grant_vld && ((state == IDLE) || k_last);

  always_comb begin
    gnt_vec = '0;
    for (int c = 0; c < NCH; c++) gnt_vec[c] = do_grant && (grant_ch == 3'(c));
    // A request landing on its own grant edge re-arms pend rather than erroring.
    pend_d = ch_req | (pend & ~gnt_vec);
    ovr_d  = ovr_err | (ch_req & pend & ~gnt_vec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_vld) state_n = SHIFT;
      SHIFT:   state_n = ISSUE;
      ISSUE:   if (k_last) state_n = grant_vld ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    cur_n = do_grant ? grant_ch : cur_ch;
    k_n   = '0;
    if (state_n == ISSUE && state == ISSUE) k_n = pair_lo + LW'(1);
    shift_en_d    = (state_n == SHIFT);
    shift_ch_d    = shift_en_d ? cur_n : 3'd0;
    ch_ack_d      = '0;
    for (int c = 0; c < NCH; c++) ch_ack_d[c] = shift_en_d && (cur_n == 3'(c));
    issue_valid_d = (state_n == ISSUE);
    issue_ch_d    = issue_valid_d ? cur_n : 3'd0;
    pair_lo_d     = k_n;
    pair_hi_d     = issue_valid_d ? K_TOP - k_n : '0;
    coe_idx_d     = k_n[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend        <= '0;
      ovr_err     <= '0;
      rr_ptr      <= 3'd0;
      cur_ch      <= 3'd0;
      shift_en    <= 1'b0;
      shift_ch    <= 3'd0;
      ch_ack      <= '0;
      issue_valid <= 1'b0;
      issue_ch    <= 3'd0;
      pair_lo     <= '0;
      pair_hi     <= '0;
      coe_idx     <= '0;
    end else begin
      pend    <= pend_d;
      ovr_err <= ovr_d;
      if (do_grant) rr_ptr <= (int'(grant_ch) == NCH - 1) ? 3'd0 : grant_ch + 3'd1;
      cur_ch      <= cur_n;
      shift_en    <= shift_en_d;
      shift_ch    <= shift_ch_d;
      ch_ack      <= ch_ack_d;
      issue_valid <= issue_valid_d;
      issue_ch    <= issue_ch_d;
      pair_lo     <= pair_lo_d;
      pair_hi     <= pair_hi_d;
      coe_idx     <= coe_idx_d;
    end
  end

  // Tag pipeline follows each issued pair through the MAC latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_l <= '0;
      tag_f <= '0;
      for (int i = 0; i <= MAC_LAT; i++) tag_c[i] <= 3'd0;
    end else begin
      tag_v[0] <= issue_valid;
      tag_l[0] <= k_last;
      tag_f[0] <= issue_valid && (pair_lo == '0);
      tag_c[0] <= issue_ch;
      for (int i = 1; i <= MAC_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
        tag_c[i] <= tag_c[i-1];
      end
      for (int i = 1; i < MAC_LAT; i++) tag_f[i] <= tag_f[i-1];
    end
  end

  assign acc_en    = tag_v[MAC_LAT-1];
  assign acc_clr   = tag_v[MAC_LAT-1] & tag_f[MAC_LAT-1];
  assign out_valid = tag_v[MAC_LAT] & tag_l[MAC_LAT];
  assign out_ch    = out_valid ? tag_c[MAC_LAT] : 3'd0;
  assign busy      = (state != IDLE) | (|tag_v);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: directed vector table, hand sequences for reset
// and overrun corners, and a schedule-level reference model under random requests.
`timescale 1ns/1ps
module tb_fir_mac_scheduler;
  localparam int NTAP = 16, NCH = 2, MAC_LAT = 2, HALF = NTAP / 2, MAXC = 2048;

  logic clk = 1'b0, rst = 1'b0;
  logic [NCH-1:0] ch_req = '0;
  logic [NCH-1:0] ch_ack, ovr_err;
  logic shift_en, issue_valid, acc_clr, acc_en, out_valid, busy;
  logic [2:0] shift_ch, issue_ch, out_ch;
  logic [3:0] pair_lo, pair_hi;
  logic [2:0] coe_idx;

  always #5 clk = ~clk;

  fir_mac_scheduler #(.NTAP(NTAP), .NCH(NCH), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_ack(ch_ack), .shift_en(shift_en),
    .shift_ch(shift_ch), .issue_valid(issue_valid), .issue_ch(issue_ch),
    .pair_lo(pair_lo), .pair_hi(pair_hi), .coe_idx(coe_idx), .acc_clr(acc_clr),
    .acc_en(acc_en), .out_valid(out_valid), .out_ch(out_ch), .busy(busy),
    .ovr_err(ovr_err));

  int total = 0, bad = 0;

  typedef struct { bit sh; int shc; bit iv; int ic; int k; bit ae; bit ac; bit ov; int oc; bit bz; } exp_t;
  typedef struct { logic [NCH-1:0] req; bit sh; bit iv; int lo; bit ac; bit ae; bit ov; bit bz; } vec_t;

  exp_t ex [MAXC];
  logic [NCH-1:0] stim [MAXC];
  vec_t tv [16];
  bit [NCH-1:0] m_pend, m_ovr;
  int m_ptr, m_next;
  int n_ov, n_act, first_act, last_act;
  int order [$];

  function automatic logic [63:0] pk(bit sh, int shc, int ack, bit iv, int ic, int lo, int hi,
                                     int coe, bit ae, bit ac, bit ov, int oc, bit bz, int ovr);
    pk = {4'(sh), 4'(shc), 4'(ack), 4'(iv), 4'(ic), 4'(lo), 4'(hi), 4'(coe),
          4'(ae), 4'(ac), 4'(ov), 4'(oc), 4'(bz), 4'(ovr), 8'h00};
  endfunction

  function automatic logic [63:0] obs_raw();
    obs_raw = pk(shift_en, int'(shift_ch), int'(ch_ack), issue_valid, int'(issue_ch),
                 int'(pair_lo), int'(pair_hi), int'(coe_idx), acc_en, acc_clr, out_valid,
                 int'(out_ch), busy, int'(ovr_err));
  endfunction

  // Fields only meaningful under their qualifier are forced to 0 otherwise.
  function automatic logic [63:0] obs_masked();
    obs_masked = pk(shift_en, shift_en ? int'(shift_ch) : 0, int'(ch_ack), issue_valid,
                    issue_valid ? int'(issue_ch) : 0, issue_valid ? int'(pair_lo) : 0,
                    issue_valid ? int'(pair_hi) : 0, issue_valid ? int'(coe_idx) : 0,
                    acc_en, acc_clr, out_valid, out_valid ? int'(out_ch) : 0, busy,
                    int'(ovr_err));
  endfunction

  function automatic logic [63:0] exp_at(int c);
    exp_t e = ex[c];
    exp_at = pk(e.sh, e.shc, e.sh ? (1 << e.shc) : 0, e.iv, e.ic, e.k,
                e.iv ? NTAP - 1 - e.k : 0, e.k, e.ae, e.ac, e.ov, e.oc, e.bz, int'(m_ovr));
  endfunction

  function automatic int ord_code();
    ord_code = 0;
    foreach (order[i]) ord_code = (ord_code << 4) | order[i];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    ch_req = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < MAXC; i++) ex[i] = '{default: 0};
    m_pend = '0; m_ovr = '0; m_ptr = 0; m_next = 0;
  endtask

  // One granted sample: SHIFT at s, pairs s+1..s+HALF, products MAC_LAT later.
  task automatic m_sched(int s, int g);
    if (s + HALF + MAC_LAT + 1 >= MAXC) return;
    ex[s].sh = 1; ex[s].shc = g;
    for (int i = 0; i < HALF; i++) begin
      ex[s+1+i].iv = 1; ex[s+1+i].ic = g; ex[s+1+i].k = i;
      ex[s+1+i+MAC_LAT].ae = 1;
    end
    ex[s+1+MAC_LAT].ac = 1;
    ex[s+HALF+MAC_LAT+1].ov = 1; ex[s+HALF+MAC_LAT+1].oc = g;
    for (int t = s; t <= s + HALF + MAC_LAT + 1; t++) ex[t].bz = 1;
  endtask

  // A request driven in cycle c is pending from c+1; a decision in cycle c shifts at c+1.
  task automatic m_step(int c, logic [NCH-1:0] req);
    int g = -1;
    if (c >= m_next && m_pend != 0) begin
      for (int i = 0; i < NCH; i++) begin
        int ch = (m_ptr + i) % NCH;
        if (g < 0 && m_pend[ch]) g = ch;
      end
      m_sched(c + 1, g);
      m_ptr  = (g + 1) % NCH;
      m_next = c + 1 + HALF;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (req[ch] && m_pend[ch] && ch != g) m_ovr[ch] = 1'b1;
      m_pend[ch] = (m_pend[ch] && ch != g) || req[ch];
    end
  endtask

  task automatic run_phase(int n, string tag);
    do_reset();
    m_clear();
    n_ov = 0; n_act = 0; first_act = -1; last_act = -1;
    order.delete();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk($sformatf("%s c%0d", tag, c), obs_masked(), exp_at(c));
      if (out_valid) n_ov++;
      if (shift_en) order.push_back(int'(shift_ch));
      if (shift_en || issue_valid) begin
        n_act++;
        if (first_act < 0) first_act = c;
        last_act = c;
      end
      m_step(c, stim[c]);
      ch_req = stim[c];
    end
    ch_req = '0;
  endtask

  task automatic clr_stim();
    for (int i = 0; i < MAXC; i++) stim[i] = '0;
  endtask

  initial begin
    int cnt, ovc, occ;

    // Single-channel vectors, cycle numbers straight from the expected timeline.
    for (int c = 0; c < 16; c++) tv[c] = '{default: 0};
    tv[0].req = 2'b01;
    tv[2].sh = 1;
    for (int c = 3; c <= 10; c++) begin tv[c].iv = 1; tv[c].lo = c - 3; end
    tv[5].ac = 1;
    for (int c = 5; c <= 12; c++) tv[c].ae = 1;
    tv[13].ov = 1;
    for (int c = 2; c <= 13; c++) tv[c].bz = 1;

    #12;
    chk("reset_state", obs_raw(), 64'h0);

    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      chk($sformatf("vec c%0d", c), obs_masked(),
          pk(tv[c].sh, 0, tv[c].sh ? 1 : 0, tv[c].iv, 0, tv[c].lo,
             tv[c].iv ? NTAP - 1 - tv[c].lo : 0, tv[c].lo, tv[c].ae, tv[c].ac,
             tv[c].ov, 0, tv[c].bz, 0));
      ch_req = tv[c].req;
    end
    ch_req = '0;

    // Reset in the middle of ISSUE k=4, with an overrun already flagged.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 7) begin
        chk("k4_before_rst", 64'(pair_lo), 64'd4);
        chk("ovr_before_rst", 64'(ovr_err), 64'd1);
        #2 rst = 1'b0;
        #1 chk("async_rst_outputs", obs_raw(), 64'h0);
      end else begin
        ch_req = (c == 0 || c == 3 || c == 5) ? 2'b01 : 2'b00;
      end
    end
    ch_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy || shift_en) cnt++;
    end
    chk("quiet_after_rst", 64'(cnt), 64'd0);
    chk("ovr_after_rst", 64'(ovr_err), 64'd0);
    ovc = -1; occ = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (out_valid && ovc < 0) begin ovc = c; occ = int'(out_ch); end
      ch_req = (c == 0) ? 2'b10 : 2'b00;
    end
    chk("rerun_ov_cycle", 64'(ovc), 64'd13);
    chk("rerun_ov_ch", 64'(occ), 64'd1);

    // Both at once, then both again: ch1 was last so ch0 leads again.
    clr_stim(); stim[0] = 2'b11; stim[30] = 2'b11;
    run_phase(60, "A");
    chk("A_order_len", 64'(order.size()), 64'd4);
    chk("A_order", 64'(ord_code()), 64'h0101);
    chk("A_nov", 64'(n_ov), 64'd4);

    // ch0 served last, then both: ch1 leads.
    clr_stim(); stim[0] = 2'b10; stim[5] = 2'b01; stim[40] = 2'b11;
    run_phase(70, "B");
    chk("B_order", 64'(ord_code()), 64'h1010);

    // Overrun on ch0 while pending; ch1 re-request on its own grant edge.
    clr_stim(); stim[0] = 2'b11; stim[4] = 2'b01; stim[6] = 2'b01; stim[10] = 2'b10;
    run_phase(50, "C");
    chk("C_ovr", 64'(ovr_err), 64'd1);
    chk("C_order", 64'(ord_code()), 64'h0101);
    chk("C_nov", 64'(n_ov), 64'd4);

    // Sustained at exactly the rated period: 18 cycles for two channels.
    clr_stim();
    for (int k = 0; k < 20; k++) stim[18*k] = 2'b11;
    run_phase(380, "D");
    chk("D_nov", 64'(n_ov), 64'd40);
    chk("D_ovr", 64'(ovr_err), 64'd0);
    chk("D_active_cycles", 64'(n_act), 64'd360);
    chk("D_first_act", 64'(first_act), 64'd2);
    chk("D_last_act", 64'(last_act), 64'd361);

    // Random sparse requests, overruns included.
    clr_stim();
    for (int c = 0; c < 1400; c++)
      for (int ch = 0; ch < NCH; ch++)
        stim[c][ch] = ($urandom_range(0, 11) == 0);
    run_phase(1500, "R");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
